// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the VGA-domain reset sequencer.
//   rs_state_t : sequencer FSM states
//   rs_cause_t : encoding of the last reset cause reported on the cause port
//   cnt_width  : bits needed to hold 0..max_count (never less than 1)
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT,
        WAIT_LOCK,
        RELEASE,
        RUN
    } rs_state_t;

    typedef enum logic [1:0] {
        CAUSE_POR,
        CAUSE_LOCK,
        CAUSE_BTN,
        CAUSE_SW
    } rs_cause_t;

    function automatic int cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : int'($clog2(max_count + 1));
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Push-button conditioner: synchronises the asynchronous active-low button into VGA_CLK
// and reports a press once DEBOUNCE_CYCLES consecutive low samples have been seen.
// Ports:
//   VGA_CLK     in  sole clock
//   rst         in  synchronous active-high reset
//   btn_n       in  raw active-low push-button (asynchronous)
//   btn_pressed out debounced press, high while the button stays held
module sync_debounce
    import reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
    input  logic VGA_CLK,
    input  logic rst,
    input  logic btn_n,
    output logic btn_pressed
);

    localparam int DbW = cnt_width(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [DbW-1:0]         low_cnt_q;

    always_ff @(posedge VGA_CLK) begin
        if (rst) begin
            // Synchroniser holds the released (high) level so reset never looks like a press.
            btn_sync_q <= '1;
            low_cnt_q  <= '0;
        end else begin
            btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn_n};
            if (btn_sync_q[SYNC_STAGES-1]) begin
                low_cnt_q <= '0;
            end else if (low_cnt_q != DbW'(DEBOUNCE_CYCLES)) begin
                low_cnt_q <= low_cnt_q + 1'b1;
            end
        end
    end

    // Counter saturates at DEBOUNCE_CYCLES, so the press holds for as long as the button does.
    assign btn_pressed = (low_cnt_q == DbW'(DEBOUNCE_CYCLES));

endmodule

// File: rtl/reset_sequencer.sv
// Reset controller for the VGA clock domain. Merges master reset, PLL lock, a debounced
// push-button and a software request, stretches any fault to at least STRETCH_CYCLES,
// waits for LOCK_STABLE cycles of lock, then releases NUM_STAGES resets in order
// (stage 0 first) STAGE_GAP cycles apart.
// Ports:
//   VGA_CLK in  sole clock
//   rst     in  synchronous active-high master reset
//   locked  in  PLL lock (asynchronous)
//   btn_n   in  active-low push-button (asynchronous)
//   sw_req  in  synchronous software reset request
//   rst_out out active-high stage resets, thermometer coded
//   ready   out high only while running
//   cause   out last reset cause (POR, LOCK_LOSS, BUTTON, SOFTWARE)
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES      = 3,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned STRETCH_CYCLES  = 1024,
    parameter int unsigned LOCK_STABLE     = 256,
    parameter int unsigned STAGE_GAP       = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
    input  logic                  VGA_CLK,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  btn_n,
    input  logic                  sw_req,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [1:0]            cause
);

    localparam int unsigned MaxAB  = (STRETCH_CYCLES > LOCK_STABLE) ? STRETCH_CYCLES
                                                                     : LOCK_STABLE;
    localparam int unsigned MaxAll = (MaxAB > STAGE_GAP) ? MaxAB : STAGE_GAP;
    localparam int          CntW   = cnt_width(MaxAll - 1);
    localparam int          IdxW   = cnt_width(NUM_STAGES - 1);

    rs_state_t              state_q;
    rs_cause_t              cause_q;
    logic [CntW-1:0]        cnt_q;
    logic [IdxW-1:0]        idx_q;
    logic [NUM_STAGES-1:0]  rst_out_q;
    logic                   ready_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;

    logic      locked_s;
    logic      btn_pressed;
    logic      lock_fault;
    logic      fault;
    rs_cause_t fault_cause;

    always_ff @(posedge VGA_CLK) begin
        if (rst) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked};
        end
    end
    assign locked_s = lock_sync_q[SYNC_STAGES-1];

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .VGA_CLK     (VGA_CLK),
        .rst         (rst),
        .btn_n       (btn_n),
        .btn_pressed (btn_pressed)
    );

    // Loss of lock only counts once the pipeline has started coming out of reset.
    assign lock_fault  = ~locked_s & ((state_q == RELEASE) | (state_q == RUN));
    assign fault       = sw_req | btn_pressed | lock_fault;
    assign fault_cause = lock_fault  ? CAUSE_LOCK :
                         btn_pressed ? CAUSE_BTN  : CAUSE_SW;

    // rst_out while releasing: stages 0..idx are out of reset, the rest still held.
    function automatic logic [NUM_STAGES-1:0] release_mask(input logic [IdxW-1:0] idx);
        logic [NUM_STAGES-1:0] m;
        for (int unsigned s = 0; s < NUM_STAGES; s++) begin
            m[s] = (s > 32'(idx));
        end
        return m;
    endfunction

    // Outputs are loaded alongside the state they belong to, so they change on the same edge.
    always_ff @(posedge VGA_CLK) begin
        if (rst) begin
            state_q   <= ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            cause_q   <= CAUSE_POR;
        end else if (fault) begin
            // A held fault keeps cnt at 0, so the stretch restarts when the fault goes away.
            state_q   <= ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            cause_q   <= fault_cause;
        end else begin
            unique case (state_q)
                ASSERT: begin
                    if (cnt_q == CntW'(STRETCH_CYCLES - 1)) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (!locked_s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CntW'(LOCK_STABLE - 1)) begin
                        state_q   <= RELEASE;
                        cnt_q     <= '0;
                        idx_q     <= '0;
                        rst_out_q <= release_mask('0);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == CntW'(STAGE_GAP - 1)) begin
                        cnt_q <= '0;
                        if (idx_q == IdxW'(NUM_STAGES - 1)) begin
                            state_q   <= RUN;
                            rst_out_q <= '0;
                            ready_q   <= 1'b1;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            rst_out_q <= release_mask(idx_q + 1'b1);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= ASSERT;
                end
            endcase
        end
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;
    assign cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int unsigned NS  = 3;
    localparam int unsigned SY  = 2;
    localparam int unsigned ST  = 4;
    localparam int unsigned LS  = 2;
    localparam int unsigned GAP = 2;
    localparam int unsigned DB  = 3;

    logic          VGA_CLK = 1'b0;
    logic          rst     = 1'b1;
    logic          locked  = 1'b1;
    logic          btn_n   = 1'b1;
    logic          sw_req  = 1'b0;
    logic [NS-1:0] rst_out;
    logic          ready;
    logic [1:0]    cause;

    reset_sequencer #(
        .NUM_STAGES      (NS),
        .SYNC_STAGES     (SY),
        .STRETCH_CYCLES  (ST),
        .LOCK_STABLE     (LS),
        .STAGE_GAP       (GAP),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .VGA_CLK (VGA_CLK),
        .rst     (rst),
        .locked  (locked),
        .btn_n   (btn_n),
        .sw_req  (sw_req),
        .rst_out (rst_out),
        .ready   (ready),
        .cause   (cause)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time-based view of the sequence. m_age counts edges since the last
    // fault, m_rel_at is the age at which release began; outputs follow arithmetically.
    bit            m_lock_h[$];
    bit            m_btn_h[$];
    int            m_low_run;
    int            m_age;
    int            m_rel_at;
    int            m_streak;
    bit            m_released;
    int            m_cause;
    logic [NS-1:0] m_rst_out;
    logic          m_ready;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit lk, input bit bn, input bit sw);
        bit ls, bs, pressed, lock_f, fault;
        int rr;
        if (r) begin
            m_lock_h = {};
            m_btn_h  = {};
            for (int i = 0; i < int'(SY); i++) begin
                m_lock_h.push_back(1'b0);
                m_btn_h.push_back(1'b1);
            end
            m_low_run  = 0;
            m_age      = 0;
            m_streak   = 0;
            m_released = 1'b0;
            m_cause    = 0;
        end else begin
            ls      = m_lock_h[0];
            bs      = m_btn_h[0];
            pressed = (m_low_run >= int'(DB));
            lock_f  = !ls && m_released;
            fault   = sw || pressed || lock_f;
            m_low_run = bs ? 0 : ((m_low_run < int'(DB)) ? m_low_run + 1 : m_low_run);
            void'(m_lock_h.pop_front());
            void'(m_btn_h.pop_front());
            m_lock_h.push_back(lk);
            m_btn_h.push_back(bn);
            if (fault) begin
                m_cause    = lock_f ? 1 : (pressed ? 2 : 3);
                m_age      = 0;
                m_streak   = 0;
                m_released = 1'b0;
            end else begin
                m_age++;
                if (!m_released && m_age > int'(ST)) begin
                    m_streak = ls ? m_streak + 1 : 0;
                    if (m_streak == int'(LS)) begin
                        m_released = 1'b1;
                        m_rel_at   = m_age;
                    end
                end
            end
        end
        if (m_released) begin
            rr      = m_age - m_rel_at;
            m_ready = (rr >= int'(NS * GAP));
            for (int i = 0; i < int'(NS); i++) m_rst_out[i] = !(rr >= i * int'(GAP));
        end else begin
            m_ready   = 1'b0;
            m_rst_out = '1;
        end
    endtask

    task automatic step(input string tag);
        bit r, lk, bn, sw;
        r  = rst;
        lk = locked;
        bn = btn_n;
        sw = sw_req;
        @(posedge VGA_CLK);
        model_edge(r, lk, bn, sw);
        #1;
        cmp({tag, " rst_out"}, 32'(rst_out), 32'(m_rst_out));
        cmp({tag, " ready"}, 32'(ready), 32'(m_ready));
        cmp({tag, " cause"}, 32'(cause), 32'(m_cause));
        for (int i = 1; i < int'(NS); i++) begin
            n_cmp++;
            if (rst_out[i] === 1'b0 && rst_out[i-1] !== 1'b0) begin
                n_bad++;
                $display("FAIL thermometer: got rst_out %b want lower stages released first",
                         rst_out);
            end
        end
    endtask

    typedef struct {
        bit         r;
        bit         lk;
        bit         bn;
        bit         sw;
        int         cyc;
        logic [2:0] ro;
        bit         rdy;
        logic [1:0] cs;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Hand-derived power-up / fault timeline (edge 0 = last edge with rst high).
        vecs.push_back('{1, 1, 1, 0, 2, 3'b111, 0, 2'd0}); // edge 0
        vecs.push_back('{0, 1, 1, 0, 5, 3'b111, 0, 2'd0}); // 5: waiting for lock
        vecs.push_back('{0, 1, 1, 0, 1, 3'b110, 0, 2'd0}); // 6: stage 0 released
        vecs.push_back('{0, 1, 1, 0, 2, 3'b100, 0, 2'd0}); // 8
        vecs.push_back('{0, 1, 1, 0, 2, 3'b000, 0, 2'd0}); // 10
        vecs.push_back('{0, 1, 1, 0, 1, 3'b000, 0, 2'd0}); // 11
        vecs.push_back('{0, 1, 1, 0, 1, 3'b000, 1, 2'd0}); // 12: RUN
        vecs.push_back('{0, 0, 1, 0, 1, 3'b000, 1, 2'd0}); // 13: one low lock sample
        vecs.push_back('{0, 1, 1, 0, 1, 3'b000, 1, 2'd0}); // 14: locked_s falls
        vecs.push_back('{0, 1, 1, 0, 1, 3'b111, 0, 2'd1}); // 15: lock-loss fault
        vecs.push_back('{0, 1, 1, 0, 6, 3'b110, 0, 2'd1}); // 21
        vecs.push_back('{0, 1, 1, 0, 6, 3'b000, 1, 2'd1}); // 27
        vecs.push_back('{0, 1, 0, 0, 2, 3'b000, 1, 2'd1}); // 29: short press
        vecs.push_back('{0, 1, 1, 0, 4, 3'b000, 1, 2'd1}); // 33: ignored
        vecs.push_back('{0, 1, 0, 0, 5, 3'b000, 1, 2'd1}); // 38: long press pending
        vecs.push_back('{0, 1, 1, 0, 1, 3'b111, 0, 2'd2}); // 39: button fault
        vecs.push_back('{0, 1, 1, 0, 2, 3'b111, 0, 2'd2}); // 41: still held
        vecs.push_back('{0, 1, 1, 0, 4, 3'b111, 0, 2'd2}); // 45
        vecs.push_back('{0, 1, 1, 0, 2, 3'b110, 0, 2'd2}); // 47
        vecs.push_back('{0, 1, 1, 0, 2, 3'b100, 0, 2'd2}); // 49: idx 1
        vecs.push_back('{0, 1, 1, 1, 1, 3'b111, 0, 2'd3}); // 50: software request
        vecs.push_back('{0, 1, 1, 0, 6, 3'b110, 0, 2'd3}); // 56
        vecs.push_back('{0, 1, 1, 0, 6, 3'b000, 1, 2'd3}); // 62
        vecs.push_back('{0, 0, 1, 0, 1, 3'b000, 1, 2'd3}); // 63
        vecs.push_back('{0, 1, 1, 0, 1, 3'b000, 1, 2'd3}); // 64
        vecs.push_back('{0, 1, 1, 1, 1, 3'b111, 0, 2'd1}); // 65: lock loss beats software
        vecs.push_back('{0, 1, 1, 0, 6, 3'b110, 0, 2'd1}); // 71
        vecs.push_back('{0, 1, 1, 0, 1, 3'b110, 0, 2'd1}); // 72
        vecs.push_back('{1, 1, 1, 0, 1, 3'b111, 0, 2'd0}); // 73: rst mid-release
        vecs.push_back('{0, 1, 1, 0, 6, 3'b110, 0, 2'd0}); // 79

        for (int v = 0; v < vecs.size(); v++) begin
            rst    = vecs[v].r;
            locked = vecs[v].lk;
            btn_n  = vecs[v].bn;
            sw_req = vecs[v].sw;
            for (int c = 0; c < vecs[v].cyc; c++) step($sformatf("vec%0d model", v));
            cmp($sformatf("vec%0d rst_out", v), 32'(rst_out), 32'(vecs[v].ro));
            cmp($sformatf("vec%0d ready", v), 32'(ready), 32'(vecs[v].rdy));
            cmp($sformatf("vec%0d cause", v), 32'(cause), 32'(vecs[v].cs));
        end

        // Randomised traffic: rare resets, lock drops, button presses of varied length.
        rst    = 1'b0;
        sw_req = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            rst = ($urandom_range(0, 511) == 0);
            if (locked) locked = ($urandom_range(0, 63) != 0);
            else        locked = ($urandom_range(0, 1) == 0);
            if (btn_n) btn_n = ($urandom_range(0, 63) != 0);
            else       btn_n = ($urandom_range(0, 3) == 0);
            sw_req = ($urandom_range(0, 127) == 0);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
